mem_access_unit: RTL and testbench

Memory-stage responder for the control unit's MemRead/MemWrite/Vec decisions: it turns one scalar or vector load/store into a sequence of single-word data-memory transactions and stalls the pipeline until the access completes. It sits between the execute/memory pipeline register and the data-memory port. A vector access touches LANES consecutive words. A scalar access touches one word.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and sizing helpers for the memory-stage access unit.
//   state_t        : access sequencer states
//   LANE_BYTES     : byte stride between consecutive elements (default geometry)
//   LANE_IDX_W     : lane counter width (default geometry)
//   lane_bytes()   : byte stride for an arbitrary element width
//   lane_idx_w()   : lane counter width for an arbitrary lane count (min 1)
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int unsigned lane_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned LANE_BYTES = DEF_DATA_W / 8;
    localparam int unsigned LANE_IDX_W = (DEF_LANES > 1) ? $clog2(DEF_LANES) : 1;

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage responder: splits a scalar or vector load/store into single-word
// data-memory transactions and stalls the pipeline until the access finishes.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   mem_read_i, mem_write_i, vec_i: pipelined control decisions (read wins)
//   addr_i, wdata_i               : base byte address, per-lane store data
//   stall_o                       : combinational pipeline hold
//   rdata_o, rdata_valid_o        : load result and one-cycle completion pulse
//   dmem_*                        : single-word request/grant, read-valid port
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read_i,
    input  logic                    mem_write_i,
    input  logic                    vec_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [LANES*DATA_W-1:0] wdata_i,
    output logic                    stall_o,
    output logic [LANES*DATA_W-1:0] rdata_o,
    output logic                    rdata_valid_o,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [ADDR_W-1:0]       dmem_addr_o,
    output logic [DATA_W-1:0]       dmem_wdata_o,
    input  logic                    dmem_gnt_i,
    input  logic                    dmem_rvalid_i,
    input  logic [DATA_W-1:0]       dmem_rdata_i
);

    localparam int unsigned LANE_W = lane_idx_w(LANES);
    localparam int unsigned STRIDE = lane_bytes(DATA_W);

    state_t                    state;
    state_t                    state_n;
    logic [LANE_W-1:0]         lane;
    logic                      op_read;
    logic                      is_vec;
    logic [ADDR_W-1:0]         base;
    logic [LANES*DATA_W-1:0]   wbuf;
    logic [LANES*DATA_W-1:0]   rdata_q;
    logic                      lane_last;
    logic [ADDR_W-1:0]         lane_addr;
    logic [DATA_W-1:0]         lane_wdata;

    // Scalar accesses finish after lane 0, vector accesses after LANES-1.
    assign lane_last  = (lane == (is_vec ? LANE_W'(LANES - 1) : '0));
    assign lane_addr  = base + (ADDR_W'(lane) * ADDR_W'(STRIDE));
    assign lane_wdata = wbuf[32'(lane)*DATA_W +: DATA_W];
    assign rdata_o    = rdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (mem_read_i || mem_write_i) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (dmem_gnt_i) begin
                    if (op_read) begin
                        state_n = WAIT_R;
                    end else if (lane_last) begin
                        state_n = DONE;
                    end
                end
            end
            WAIT_R: begin
                if (dmem_rvalid_i) begin
                    state_n = lane_last ? DONE : ISSUE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from registered state; only stall looks at live inputs.
    always_comb begin
        stall_o       = ((state == IDLE) && (mem_read_i || mem_write_i))
                        || (state == ISSUE) || (state == WAIT_R);
        dmem_req_o    = (state == ISSUE);
        dmem_we_o     = (state == ISSUE) && !op_read;
        dmem_addr_o   = (state == ISSUE) ? lane_addr  : '0;
        dmem_wdata_o  = (state == ISSUE) ? lane_wdata : '0;
        rdata_valid_o = (state == DONE) && op_read;
    end

    // Request capture, lane sequencing and load-result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane    <= '0;
            op_read <= 1'b0;
            is_vec  <= 1'b0;
            base    <= '0;
            wbuf    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read_i || mem_write_i) begin
                        op_read <= mem_read_i;
                        is_vec  <= vec_i;
                        base    <= addr_i;
                        wbuf    <= wdata_i;
                        lane    <= '0;
                    end
                end
                ISSUE: begin
                    if (dmem_gnt_i && !op_read && !lane_last) begin
                        lane <= lane + LANE_W'(1);
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid_i) begin
                        // A scalar load clears the upper lanes.
                        if (is_vec) begin
                            rdata_q[32'(lane)*DATA_W +: DATA_W] <= dmem_rdata_i;
                        end else begin
                            rdata_q <= (LANES*DATA_W)'(dmem_rdata_i);
                        end
                        if (!lane_last) begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected memory transactions and read
// responses are queued when each access is launched and consumed as the DUT
// issues requests.
module tb_mem_access_unit;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANES  = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    mem_read_i;
    logic                    mem_write_i;
    logic                    vec_i;
    logic [ADDR_W-1:0]       addr_i;
    logic [LANES*DATA_W-1:0] wdata_i;
    logic                    stall_o;
    logic [LANES*DATA_W-1:0] rdata_o;
    logic                    rdata_valid_o;
    logic                    dmem_req_o;
    logic                    dmem_we_o;
    logic [ADDR_W-1:0]       dmem_addr_o;
    logic [DATA_W-1:0]       dmem_wdata_o;
    logic                    dmem_gnt_i;
    logic                    dmem_rvalid_i;
    logic [DATA_W-1:0]       dmem_rdata_i;

    txn_t              exp_q[$];
    logic [DATA_W-1:0] resp_q[$];
    int                tests = 0;
    int                fails = 0;

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .vec_i         (vec_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one access at a negedge in IDLE and run it to completion.
    // Grant is withheld for hold_cycles on the request of lane hold_lane.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic vc,
                          input logic [ADDR_W-1:0] a, input logic [LANES*DATA_W-1:0] wd,
                          input logic [LANES*DATA_W-1:0] exp_rd, input int hold_lane,
                          input int hold_cycles, input int exp_stall, input int exp_vp);
        int   stalls = 0;
        int   vp     = 0;
        int   grants = 0;
        int   held   = 0;
        bit   pend   = 1'b0;
        bit   done   = 1'b0;
        txn_t e;
        mem_read_i  = rd;
        mem_write_i = wr;
        vec_i       = vc;
        addr_i      = a;
        wdata_i     = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            dmem_rvalid_i = pend;
            dmem_rdata_i  = '0;
            if (pend && resp_q.size() > 0) dmem_rdata_i = resp_q.pop_front();
            pend = 1'b0;
            if (dmem_req_o && grants == hold_lane && held < hold_cycles) begin
                dmem_gnt_i = 1'b0;
                held++;
            end else begin
                dmem_gnt_i = 1'b1;
            end
            #1;
            if (!dmem_gnt_i && dmem_req_o && exp_q.size() > 0) begin
                chk({name, "_hold_addr"},  128'(dmem_addr_o),  128'(exp_q[0].addr));
                chk({name, "_hold_wdata"}, 128'(dmem_wdata_o), 128'(exp_q[0].wdata));
                chk({name, "_hold_we"},    128'(dmem_we_o),    128'(exp_q[0].we));
            end
            if (stall_o) begin
                stalls++;
            end else if (cyc > 0) begin
                done        = 1'b1;
                mem_read_i  = 1'b0;
                mem_write_i = 1'b0;
            end
            if (dmem_req_o && dmem_gnt_i) begin
                if (exp_q.size() == 0) begin
                    chk({name, "_extra_req"}, 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk({name, "_req"}, 128'({dmem_we_o, dmem_addr_o, dmem_wdata_o}), 128'(e));
                    if (!e.we) pend = 1'b1;
                end
                grants++;
            end
            if (rdata_valid_o) begin
                vp++;
                chk({name, "_rdata"}, 128'(rdata_o), 128'(exp_rd));
            end
            @(negedge clk);
        end
        if (!done) chk({name, "_timeout"}, 128'(0), 128'(1));
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b0;
        #1;
        chk({name, "_valid_after"}, 128'(rdata_valid_o), 128'(0));
        chk({name, "_stall_cycles"}, 128'(stalls), 128'(exp_stall));
        chk({name, "_valid_pulses"}, 128'(vp), 128'(exp_vp));
        chk({name, "_txn_left"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        mem_read_i = 1'b0; mem_write_i = 1'b0; vec_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 128'(stall_o), 128'(0));
        chk("rst_rdata", 128'(rdata_o), 128'(0));
        chk("rst_valid", 128'(rdata_valid_o), 128'(0));
        chk("rst_dmem", 128'({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o}), 128'(0));
        @(negedge clk);

        // Scalar store.
        exp_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF});
        run_op("st_scalar", 1'b0, 1'b1, 1'b0, 32'h100, 128'hDEADBEEF, '0, -1, 0, 2, 0);

        // Vector load.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{we: 1'b0, addr: 32'h200 + 32'(4*k), wdata: 32'h0});
            resp_q.push_back(32'h11 * 32'(k + 1));
        end
        run_op("ld_vec", 1'b1, 1'b0, 1'b1, 32'h200, '0,
               128'h00000044_00000033_00000022_00000011, -1, 0, 9, 1);
        chk("ld_vec_hold_result", 128'(rdata_o), 128'h00000044_00000033_00000022_00000011);

        // Scalar load clears upper lanes of the previous vector result.
        exp_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
        resp_q.push_back(32'hCAFEF00D);
        run_op("ld_scalar", 1'b1, 1'b0, 1'b0, 32'h300, '0, 128'hCAFEF00D, -1, 0, 3, 1);

        // Vector store with grant withheld three cycles on lane 2.
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{we: 1'b1, addr: 32'h200 + 32'(4*k), wdata: 32'hA0A0_0000 + 32'(k)});
        run_op("st_vec_bp", 1'b0, 1'b1, 1'b1, 32'h200,
               128'hA0A00003_A0A00002_A0A00001_A0A00000, '0, 2, 3, 8, 0);

        // Read and write together: only the read happens.
        exp_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h12345678});
        resp_q.push_back(32'h55);
        run_op("rw_both", 1'b1, 1'b1, 1'b0, 32'h500, 128'h12345678, 128'h55, -1, 0, 3, 1);

        // Stray rvalid while idle.
        @(negedge clk);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hBAD0BAD0;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        #1;
        chk("stray_rdata", 128'(rdata_o), 128'h55);
        chk("stray_valid", 128'(rdata_valid_o), 128'(0));
        chk("stray_stall", 128'(stall_o), 128'(0));

        // Reset while waiting for lane 1 of a vector load.
        @(negedge clk);
        mem_read_i = 1'b1; vec_i = 1'b1; addr_i = 32'h600; wdata_i = '0;
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        #1 chk("rst_mid_l0_addr", 128'(dmem_addr_o), 128'h600);
        @(negedge clk);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h77;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        #1 chk("rst_mid_l1_addr", 128'(dmem_addr_o), 128'h604);
        @(negedge clk);
        #1;
        chk("rst_mid_wait_stall", 128'(stall_o), 128'(1));
        chk("rst_mid_wait_req", 128'(dmem_req_o), 128'(0));
        rst = 1'b1; mem_read_i = 1'b0; vec_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h99;
        #1;
        chk("rst_mid_stall", 128'(stall_o), 128'(0));
        chk("rst_mid_rdata", 128'(rdata_o), 128'(0));
        chk("rst_mid_dmem", 128'({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o}), 128'(0));
        chk("rst_mid_valid", 128'(rdata_valid_o), 128'(0));
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
        #1;
        chk("late_rvalid_rdata", 128'(rdata_o), 128'(0));
        chk("late_rvalid_stall", 128'(stall_o), 128'(0));
        @(negedge clk);

        // Fresh scalar load after the reset.
        exp_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'h0});
        resp_q.push_back(32'h0000ABCD);
        run_op("ld_after_rst", 1'b1, 1'b0, 1'b0, 32'h700, '0, 128'h0000ABCD, -1, 0, 3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
